// File: rtl/mul_disp_pkg.sv
// Shared types and constants for the multiplier display path: FSM encoding,
// default converter widths and active-low gfedcba seven-segment patterns.
package mul_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEF_IN_W   = 8;
    localparam int DEF_DIGITS = 3;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low gfedcba pattern; combinational, no backpressure.
// Only built with BCD_SEG_OUT_EN; codes 10-15 decode to blank.
`ifdef BCD_SEG_OUT_EN
module seg7_decode
    import mul_disp_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`endif

// File: rtl/bcd_seq_convert.sv
// Double-dabble binary-to-BCD converter fed by the multiplier's done/p; BCD_SEG_OUT_EN adds seg.
// Latency: rising edge of in_valid sampled at edge N -> out_valid after edge N+IN_W+1.
// No backpressure: rising edges arriving while busy are dropped, never queued.
module bcd_seq_convert
    import mul_disp_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int DIGITS = DEF_DIGITS
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [IN_W-1:0]       in_data,
    output logic                  busy,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_SEG_OUT_EN
    ,
    output logic [7*DIGITS-1:0]   seg
`endif
);

    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int BCD_W = 4 * DIGITS;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_in_valid_q;
    logic               w_trigger;
    logic [IN_W-1:0]    r_bin_sh;
    logic [BCD_W-1:0]   r_bcd_sh;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic [BCD_W-1:0]   r_bcd;

    // in_valid_q follows in_valid in every state so a held level never retriggers.
    assign w_trigger = in_valid & ~r_in_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_trigger) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_cnt == CNT_W'(IN_W - 1)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Add-3 correction happens before each shift, so the final shift leaves every digit <= 9.
    always_comb begin
        w_bcd_adj = r_bcd_sh;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd_sh[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd_sh[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_valid_q <= 1'b0;
            r_bin_sh     <= '0;
            r_bcd_sh     <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_bcd        <= '0;
        end else begin
            r_in_valid_q <= in_valid;
            r_out_valid  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_bin_sh <= in_data;
                        r_bcd_sh <= '0;
                        r_cnt    <= '0;
                    end
                end
                ST_SHIFT: begin
                    {r_bcd_sh, r_bin_sh} <= {w_bcd_adj, r_bin_sh} << 1;
                    r_cnt                <= r_cnt + CNT_W'(1);
                end
                ST_DONE: begin
                    r_bcd       <= r_bcd_sh;
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign bcd       = r_bcd;

`ifdef BCD_SEG_OUT_EN
    logic [7*DIGITS-1:0] w_seg;
    logic [7*DIGITS-1:0] r_seg;

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_decode u_seg7_decode (
            .i_digit (r_bcd_sh[4*g +: 4]),
            .o_seg   (w_seg[7*g +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= '1;
        end else if (r_state == ST_DONE) begin
            r_seg <= w_seg;
        end
    end

    assign seg = r_seg;
`endif

endmodule

// File: tb/tb_bcd_seq_convert.sv
// Scoreboard bench for bcd_seq_convert; seg checks run only with BCD_SEG_OUT_EN.
module tb_bcd_seq_convert;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        busy;
    logic        out_valid;
    logic [11:0] bcd;
`ifdef BCD_SEG_OUT_EN
    logic [20:0] seg;
`endif

    int checks   = 0;
    int errors   = 0;
    int n_pulses = 0;
    logic [11:0] sb[$];
    logic [11:0] mon_exp;

    bcd_seq_convert #(.IN_W(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy),
        .out_valid (out_valid),
        .bcd       (bcd)
`ifdef BCD_SEG_OUT_EN
        ,
        .seg       (seg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] model(input int v);
        model = {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_model(input logic [3:0] d);
        case (d)
            4'd0:    seg_model = 7'b1000000;
            4'd1:    seg_model = 7'b1111001;
            4'd2:    seg_model = 7'b0100100;
            4'd3:    seg_model = 7'b0110000;
            4'd4:    seg_model = 7'b0011001;
            4'd5:    seg_model = 7'b0010010;
            4'd6:    seg_model = 7'b0000010;
            4'd7:    seg_model = 7'b1111000;
            4'd8:    seg_model = 7'b0000000;
            4'd9:    seg_model = 7'b0010000;
            default: seg_model = 7'b1111111;
        endcase
    endfunction

    // Output side of the scoreboard: every pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_pulses++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_pulse: got bcd=%h, required no pulse", bcd);
            end else begin
                mon_exp = sb.pop_front();
                if (bcd !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_bcd: got %h, required %h", bcd, mon_exp);
                end
`ifdef BCD_SEG_OUT_EN
                checks++;
                if (seg !== {seg_model(mon_exp[11:8]), seg_model(mon_exp[7:4]), seg_model(mon_exp[3:0])}) begin
                    errors++;
                    $display("FAIL sb_seg: got %b for bcd %h", seg, mon_exp);
                end
`endif
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++; if (bcd !== 12'h000)    begin errors++; $display("FAIL reset_bcd: got %h, required 000", bcd); end
`ifdef BCD_SEG_OUT_EN
        checks++; if (seg !== {21{1'b1}}) begin errors++; $display("FAIL reset_seg: got %b, required all ones", seg); end
`endif
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_convert(input logic [7:0] v);
        int k;
        int p0;
        logic busy_ok;
        @(posedge clk); #1 in_data = v; in_valid = 1'b1;
        sb.push_back(model(v));
        p0 = n_pulses;
        @(posedge clk); #1 in_valid = 1'b0;
        busy_ok = 1'b1;
        k = 0;
        while (k < 30) begin
            @(negedge clk); k++;
            if (out_valid) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        checks++; if (k - 1 != 9)    begin errors++; $display("FAIL conv_latency(%0d): got %0d, required 9", v, k - 1); end
        checks++; if (!busy_ok)      begin errors++; $display("FAIL conv_busy_high(%0d): busy dropped, required high", v); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL conv_busy_low(%0d): got %b, required 0", v, busy); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL conv_pulse_width(%0d): got %b, required 0", v, out_valid); end
        repeat (3) @(negedge clk);
        checks++; if (n_pulses - p0 != 1) begin errors++; $display("FAIL conv_pulses(%0d): got %0d, required 1", v, n_pulses - p0); end
    endtask

    task automatic test_held;
        int p0;
        @(posedge clk); #1 in_data = 8'd42; in_valid = 1'b1;
        sb.push_back(model(42));
        p0 = n_pulses;
        repeat (30) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (n_pulses - p0 != 1) begin errors++; $display("FAIL held_pulses: got %0d, required 1", n_pulses - p0); end
        @(posedge clk); #1 in_data = 8'd77; in_valid = 1'b1;
        sb.push_back(model(77));
        p0 = n_pulses;
        repeat (15) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (n_pulses - p0 != 1) begin errors++; $display("FAIL held_second_edge: got %0d, required 1", n_pulses - p0); end
    endtask

    task automatic test_ignore_busy;
        int p0;
        @(posedge clk); #1 in_data = 8'd100; in_valid = 1'b1;
        sb.push_back(model(100));
        p0 = n_pulses;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 in_valid = 1'b1; in_data = 8'd200;
        repeat (20) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (n_pulses - p0 != 1) begin errors++; $display("FAIL ignore_busy_pulses: got %0d, required 1", n_pulses - p0); end
    endtask

    task automatic test_back_to_back;
        int k;
        @(posedge clk); #1 in_data = 8'd12; in_valid = 1'b1;
        sb.push_back(model(12));
        @(posedge clk); #1 in_valid = 1'b0;
        k = 0;
        while (k < 30) begin
            @(negedge clk); k++;
            if (out_valid) break;
        end
        checks++; if (k - 1 != 9) begin errors++; $display("FAIL b2b_first_latency: got %0d, required 9", k - 1); end
        in_data = 8'd34; in_valid = 1'b1;
        sb.push_back(model(34));
        @(posedge clk); #1 in_valid = 1'b0;
        k = 0;
        while (k < 30) begin
            @(negedge clk); k++;
            if (out_valid) break;
        end
        checks++; if (k - 1 != 9) begin errors++; $display("FAIL b2b_second_latency: got %0d, required 9", k - 1); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int p0;
        @(posedge clk); #1 in_data = 8'd150; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        p0 = n_pulses;
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
        checks++; if (bcd !== 12'h000)    begin errors++; $display("FAIL rst_mid_bcd: got %h, required 000", bcd); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b, required 0", out_valid); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (n_pulses - p0 != 0) begin errors++; $display("FAIL rst_mid_no_pulse: got %0d, required 0", n_pulses - p0); end
    endtask

    task automatic test_reset_release;
        int p0;
        @(posedge clk); #1 rst = 1'b1; in_valid = 1'b1; in_data = 8'd37;
        repeat (2) @(posedge clk);
        sb.push_back(model(37));
        p0 = n_pulses;
        #1 rst = 1'b0;
        repeat (15) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (n_pulses - p0 != 1) begin errors++; $display("FAIL rst_release_pulses: got %0d, required 1", n_pulses - p0); end
    endtask

    task automatic test_seg;
        test_convert(8'd7);
`ifdef BCD_SEG_OUT_EN
        checks++;
        if (seg !== {7'b1000000, 7'b1000000, 7'b1111000}) begin
            errors++; $display("FAIL seg_seven: got %b, required 100000010000001111000", seg);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_convert(8'd225);
        test_convert(8'd0);
        test_convert(8'd255);
        test_convert(8'd99);
        test_held;
        test_ignore_busy;
        test_back_to_back;
        test_reset_mid;
        test_reset_release;
        test_seg;
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
